// File: rtl/sm_split_tx_pkg.sv
// Shared types and default geometry for the group-sum beat transmitter.
// Package sm_pkg; the optional gap feature is enabled by SM_SPLIT_TX_GAP_EN.
package sm_pkg;

   localparam int BEATS = 3;
   localparam int LANES = 2;
   localparam int DW    = 4;
   localparam int SW    = 7;
   localparam int CNT_W = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_e;

   typedef logic [DW-1:0] lane_t;

endpackage

// File: rtl/sm_split_tx_if.sv
// Group input handshake plus beat output bus of the group-sum transmitter.
// master = stream source / scoreboard side, slave = sm_split_tx.
interface sm_split_tx_if
   import sm_pkg::*;
#(
   parameter int BEATS = sm_pkg::BEATS,
   parameter int LANES = sm_pkg::LANES,
   parameter int DW    = sm_pkg::DW,
   parameter int SW    = sm_pkg::SW
);

   logic                        in_valid;
   logic                        in_ready;
   logic [BEATS*LANES*DW-1:0]   in_data;
   logic [3:0]                  gap;
   logic                        o_dval;
   logic [LANES*DW-1:0]         o;
   logic                        o_last;
   logic [SW-1:0]               o_sum;
   logic                        busy;

   modport master (
      output in_valid, in_data, gap,
      input  in_ready, o_dval, o, o_last, o_sum, busy
   );

   modport slave (
      input  in_valid, in_data, gap,
      output in_ready, o_dval, o, o_last, o_sum, busy
   );

endinterface

// File: rtl/sm_split_tx_lane_adder.sv
// Combinational sum of LANES zero-extended lanes, truncated to SW bits.
module sm_lane_adder
   import sm_pkg::*;
#(
   parameter int LANES = sm_pkg::LANES,
   parameter int DW    = sm_pkg::DW,
   parameter int SW    = sm_pkg::SW
) (
   input  logic [LANES*DW-1:0] lanes,
   output logic [SW-1:0]       sum
);

   always_comb begin
      sum = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         sum = sum + SW'(lanes[l*DW +: DW]);
      end
   end

endmodule

// File: rtl/sm_split_tx.sv
// Serializes one packed group into BEATS dval beats and reports the group sum on the last beat.
// Define SM_SPLIT_TX_GAP_EN to insert `gap` idle cycles after every non-last beat.
module sm_split_tx
   import sm_pkg::*;
#(
   parameter int BEATS = sm_pkg::BEATS,
   parameter int LANES = sm_pkg::LANES,
   parameter int DW    = sm_pkg::DW,
   parameter int SW    = sm_pkg::SW
) (
   input logic          clk,
   input logic          rst,
   sm_split_tx_if.slave bus
);

   localparam int            CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int            BW   = LANES * DW;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   state_e                    state;
   logic [CW-1:0]             beat_cnt;
   logic [BEATS*BW-1:0]       buf_q;
   logic [SW-1:0]             acc;

   logic                      load;
   logic                      at_last;
   logic                      advance;
   logic                      nxt_last;
   logic [CW-1:0]             nxt_idx;
   logic [BW-1:0]             nxt_beat;
   logic [SW-1:0]             acc_base;
   logic [SW-1:0]             part_sum;

`ifdef SM_SPLIT_TX_GAP_EN
   logic [3:0]                gap_cnt;
   logic                      gap_go;
`else
   logic                      unused_gap;
   assign unused_gap = ^bus.gap;
`endif

   // Outputs are registered, so the datapath always prepares the beat to be shown next.
   always_comb begin
      load     = bus.in_valid && bus.in_ready;
      at_last  = (beat_cnt == LAST);
      nxt_idx  = load ? '0 : beat_cnt + CW'(1);
      nxt_beat = load ? bus.in_data[BW-1:0] : buf_q[int'(nxt_idx)*BW +: BW];
      nxt_last = (nxt_idx == LAST);
      acc_base = load ? '0 : acc;
`ifdef SM_SPLIT_TX_GAP_EN
      gap_go   = (state == SEND) && !at_last && (bus.gap != '0);
      advance  = load
               || ((state == SEND) && !at_last && (bus.gap == '0))
               || ((state == GAP) && (gap_cnt == '0));
`else
      advance  = load || ((state == SEND) && !at_last);
`endif
   end

   sm_lane_adder #(
      .LANES (LANES),
      .DW    (DW),
      .SW    (SW)
   ) u_lane_adder (
      .lanes (nxt_beat),
      .sum   (part_sum)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         buf_q        <= '0;
         acc          <= '0;
         bus.in_ready <= 1'b1;
         bus.o_dval   <= 1'b0;
         bus.o        <= '0;
         bus.o_last   <= 1'b0;
         bus.o_sum    <= '0;
         bus.busy     <= 1'b0;
`ifdef SM_SPLIT_TX_GAP_EN
         gap_cnt      <= '0;
`endif
      end else if (advance) begin
         state        <= SEND;
         beat_cnt     <= nxt_idx;
         if (load) begin
            buf_q <= bus.in_data;
         end
         bus.o_dval   <= 1'b1;
         bus.o        <= nxt_beat;
         bus.o_last   <= nxt_last;
         bus.busy     <= 1'b1;
         // Ready while the last beat is on the bus lets the next group follow without a bubble.
         bus.in_ready <= nxt_last;
         if (nxt_last) begin
            bus.o_sum <= acc_base + part_sum;
            acc       <= '0;
         end else begin
            acc       <= acc_base + part_sum;
         end
`ifdef SM_SPLIT_TX_GAP_EN
      end else if (gap_go) begin
         state        <= GAP;
         gap_cnt      <= bus.gap - 4'd1;
         bus.o_dval   <= 1'b0;
         bus.o_last   <= 1'b0;
         bus.in_ready <= 1'b0;
      end else if (state == GAP) begin
         gap_cnt      <= gap_cnt - 4'd1;
`endif
      end else begin
         state        <= IDLE;
         bus.o_dval   <= 1'b0;
         bus.o_last   <= 1'b0;
         bus.in_ready <= 1'b1;
         bus.busy     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sm_split_tx.sv
// Bench for sm_split_tx: directed steps then random traffic against a per-cycle output queue model.
// A second instance with SW=5 shares the stimulus to check sum wrap-around.
module tb_sm_split_tx;

   localparam int BEATS = 3;
   localparam int LANES = 2;
   localparam int DW    = 4;
   localparam int BW    = LANES * DW;
   localparam int GW    = BEATS * BW;

   typedef struct {
      bit             dval;
      bit             last;
      bit             inflight;
      logic [BW-1:0]  o;
      int             sum;
   } rec_t;

   logic clk;
   logic rst;

   int checks = 0;
   int passes = 0;

   rec_t q[$];
   rec_t cur;

   sm_split_tx_if #(.BEATS(BEATS), .LANES(LANES), .DW(DW), .SW(7)) ifa ();
   sm_split_tx_if #(.BEATS(BEATS), .LANES(LANES), .DW(DW), .SW(5)) ifb ();

   assign ifb.in_valid = ifa.in_valid;
   assign ifb.in_data  = ifa.in_data;
   assign ifb.gap      = ifa.gap;

   sm_split_tx #(.BEATS(BEATS), .LANES(LANES), .DW(DW), .SW(7)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   sm_split_tx #(.BEATS(BEATS), .LANES(LANES), .DW(DW), .SW(5)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic model_reset();
      q.delete();
      cur = '{dval: 1'b0, last: 1'b0, inflight: 1'b0, o: '0, sum: 0};
   endtask

   // Queue every future output cycle of a group: beats, with gap idles between non-last beats.
   task automatic push_group(input logic [GW-1:0] d, input int g);
      int   tot;
      rec_t r;
      tot = 0;
      for (int i = 0; i < BEATS * LANES; i++) tot += int'(d[i*DW +: DW]);
      for (int b = 0; b < BEATS; b++) begin
         r.dval     = 1'b1;
         r.last     = (b == BEATS - 1);
         r.inflight = 1'b1;
         r.o        = d[b*BW +: BW];
         r.sum      = r.last ? tot : 0;
         q.push_back(r);
         if (b != BEATS - 1) begin
            for (int k = 0; k < g; k++) begin
               r.dval = 1'b0;
               r.last = 1'b0;
               r.sum  = 0;
               q.push_back(r);
            end
         end
      end
   endtask

   task automatic compare_all();
      check("o_dval",   ifa.o_dval,   cur.dval);
      check("o",        ifa.o,        cur.o);
      check("o_last",   ifa.o_last,   cur.last);
      check("o_sum7",   ifa.o_sum,    cur.sum % 128);
      check("in_ready", ifa.in_ready, (q.size() == 0));
      check("busy",     ifa.busy,     cur.inflight);
      check("o_dval_b", ifb.o_dval,   cur.dval);
      check("o_sum5",   ifb.o_sum,    cur.sum % 32);
   endtask

   task automatic step(output bit acc);
      rec_t r;
      int   g;
      @(posedge clk);
`ifdef SM_SPLIT_TX_GAP_EN
      g = int'(ifa.gap);
`else
      g = 0;
`endif
      acc = ifa.in_valid && (q.size() == 0);
      if (acc) push_group(ifa.in_data, g);
      if (q.size() > 0) begin
         r = q.pop_front();
         if (!r.dval) r.o = cur.o;
         if (!r.last) r.sum = cur.sum;
      end else begin
         r          = cur;
         r.dval     = 1'b0;
         r.last     = 1'b0;
         r.inflight = 1'b0;
      end
      cur = r;
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(a);
   endtask

   task automatic send_group(input logic [GW-1:0] d);
      bit a;
      a            = 1'b0;
      ifa.in_valid = 1'b1;
      ifa.in_data  = d;
      for (int n = 0; n < 40 && !a; n++) step(a);
      check("accept_timeout", a, 1'b1);
      ifa.in_valid = 1'b0;
   endtask

   initial begin
      bit a;
      ifa.in_valid = 1'b0;
      ifa.in_data  = '0;
      ifa.gap      = '0;
      rst          = 1'b1;
      model_reset();

      // Reset state
      #1 rst = 1'b0;
      #2 compare_all();
      @(posedge clk);
      #2 rst = 1'b1;
      idle(2);

      // Single group (1,2),(3,4),(5,6): sum 21 on the third beat
      send_group(24'h654321);
      check("tp1_o0", ifa.o, 8'h21);
      idle(2);
      check("tp1_last",  ifa.o_last,   1'b1);
      check("tp1_sum",   ifa.o_sum,    7'd21);
      check("tp1_ready", ifa.in_ready, 1'b1);
      idle(2);

      // Back-to-back: second group all 15s, held valid while first is in flight
      send_group(24'h654321);
      send_group(24'hFFFFFF);
      idle(2);
      check("b2b_sum7", ifa.o_sum, 7'd90);
      check("b2b_sum5", ifb.o_sum, 5'd26);
      idle(2);

      // Reset during the second beat drops the group
      send_group(24'hABCDEF);
      idle(1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("rst_dval",  ifa.o_dval,   1'b0);
      check("rst_ready", ifa.in_ready, 1'b1);
      check("rst_busy",  ifa.busy,     1'b0);
      compare_all();
      #1 rst = 1'b1;
      idle(2);
      send_group(24'h770000);
      idle(2);
      check("post_rst_sum", ifa.o_sum, 7'd14);
      idle(2);

`ifdef SM_SPLIT_TX_GAP_EN
      // Two idle cycles between beats, none after the last
      ifa.gap = 4'd2;
      send_group(24'h654321);
      idle(1);
      check("gap_idle",  ifa.o_dval,   1'b0);
      check("gap_ready", ifa.in_ready, 1'b0);
      idle(5);
      check("gap_last",  ifa.o_last,   1'b1);
      check("gap_sum",   ifa.o_sum,    7'd21);
      idle(2);
      ifa.gap = 4'd0;
`endif

      // Random traffic; gap only changes while nothing is in flight
      for (int c = 0; c < 600; c++) begin
         if (q.size() == 0 && !cur.inflight) ifa.gap = 4'($urandom_range(0, 3));
         ifa.in_valid = ($urandom_range(0, 3) != 0);
         ifa.in_data  = ($urandom_range(0, 7) == 0) ? {GW{1'b1}} : GW'($urandom());
         step(a);
      end
      ifa.in_valid = 1'b0;
      idle(20);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sm_split_tx.md
Name: sm_split_tx

Overview:
- Transmit side of the group-sum beat protocol: accepts one packed group (BEATS beats x LANES lanes x DW bits) per valid/ready handshake.
- Serializes the group into BEATS consecutive dval-qualified beats for the downstream accumulator.
- Also emits the expected group sum, the modular sum of all lane values in the group, alongside the last beat for scoreboarding.
- Sits between the testbench/stream source and the accumulator; the downstream side has no backpressure.

Parameters:
- BEATS, 3, beats per group (>=2).
- LANES, 2, lanes per beat.
- DW, 4, bits per lane.
- SW, 7, width of expected-sum output; the sum wraps mod 2^SW.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  group available.
- in_ready  output  1  block can take a group this cycle.
- in_data  input  BEATS*LANES*DW  packed group; beat b lane l at bits [(b*LANES+l)*DW +: DW].
- gap  input  4  idle cycles between beats; used only with the optional feature.
- o_dval  output  1  beat valid.
- o  output  LANES*DW  beat lanes, lane l at [l*DW +: DW].
- o_last  output  1  high with o_dval on the final beat of a group.
- o_sum  output  SW  expected group sum; valid when o_last is high.
- busy  output  1  group in flight.

Behaviour:
- All outputs are registered.
- Reset values: o_dval=0, o=0, o_last=0, o_sum=0, busy=0, in_ready=1, state IDLE, beat counter 0, group buffer 0.
- Accept: a group is taken on a cycle with in_valid && in_ready. The first beat appears on o_dval the next cycle (latency 1).
- FSM states:
  - IDLE: in_ready=1. On accept, load the buffer, set beat_cnt=0, go to SEND.
  - SEND: each cycle drive beat beat_cnt. If beat_cnt==BEATS-1, assert o_last and o_sum, then go to IDLE, or reload if a new group is accepted the same cycle. Otherwise increment beat_cnt and stay in SEND (or go to GAP when the feature is on and gap!=0).
  - GAP: o_dval=0. Count down gap-1..0, then return to SEND.
- in_ready=1 in IDLE, and in SEND on the last beat with no gap pending. This allows back-to-back groups with no idle cycle: BEATS beats per BEATS cycles sustained.
- in_valid with in_ready=0 is held by the source and ignored by this block. in_data is sampled only on accept.
- Sum arithmetic:
  - Accumulate each lane zero-extended to SW. Truncate mod 2^SW.
  - o_sum is registered with the last beat.
  - Defaults: max 90, no wrap.
- o and o_sum hold their last values when o_dval=0. o_last is only ever high together with o_dval.
- busy=1 from accept until the cycle after the last beat, unless the next group was accepted on that last beat.
- Reset mid-group: everything clears asynchronously and the partial group is dropped. The first cycle after deassertion is IDLE with in_ready=1.
- gap is sampled when leaving each beat; changing it mid-group affects only subsequent gaps.

Optional Feature:
- Macro SM_SPLIT_TX_GAP_EN.
- Defined: the GAP state exists. After every non-last beat, insert `gap` idle cycles (o_dval=0). No gap is inserted after the last beat. in_ready stays 0 during GAP.
- Undefined: the gap port is present but ignored, the GAP state is not compiled, and beats are always contiguous.

Decomposition:
- Package sm_pkg holds:
  - localparams BEATS, LANES, DW, SW defaults;
  - CNT_W = $clog2(BEATS);
  - typedef state_e {IDLE, SEND, GAP};
  - typedef lane_t logic [DW-1:0].
- One natural sub-module, sm_lane_adder: combinational, sums LANES lanes into SW bits. It is instantiated once for the per-beat partial sum feeding the accumulator.

Test Plan:
- Single group {(1,2),(3,4),(5,6)}, defaults, gap=0 -> accept at t0. o_dval at t1..t3 with o=(1,2),(3,4),(5,6). o_last at t3 with o_sum=21. in_ready=1 at t3.
- Two groups back-to-back, in_valid held: group 2 = all 15s -> six consecutive o_dval cycles, no bubble. Second o_last has o_sum=90.
- Wrap: SW=5, all lanes 15 -> o_sum=90 mod 32=26.
- Backpressure: in_valid high during beats 1-2 of a group -> not accepted until the last-beat cycle. in_data changes while waiting are not sampled.
- Async reset asserted after beat 2 of a group -> o_dval=0 immediately. No o_last is ever seen for that group. After release, in_ready=1 and the next group {(0,0),(0,0),(7,7)} gives o_sum=14.
- With SM_SPLIT_TX_GAP_EN, gap=2 -> beats at t1, t4, t7. o_last at t7. in_ready=0 during t2..t6.
